regfile_wport_sched: RTL and testbench

- Scheduler for the single write port of the 32x32 register file.
- After reset, sequences a zero-clear of x1..x31 while holding the pipeline stalled.
- Then shares the write port between pipeline writeback (priority) and a debug/loader write requester over a valid/ready handshake.
- Starvation guard stalls the pipeline so debug writes cannot wait forever. Sits between the WB stage and the register file write inputs.

---
 rtl/rf_sched_pkg.sv | 14 +
 rtl/regfile_wport_sched_if.sv | 33 +++
 rtl/regfile_wport_sched_starve_counter.sv | 34 +++
 rtl/regfile_wport_sched.sv | 151 +++++++++++++++
 tb/tb_regfile_wport_sched.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/rf_sched_pkg.sv
// Shared types and constants for the register-file write-port scheduler.
package rf_sched_pkg;

    localparam int RF_IDX_W = 5;
    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } sched_state_e;

endpackage

// File: rtl/regfile_wport_sched_if.sv
// Bundle of the writeback, debug-write and register-file write-port signals.
// slave: the scheduler. master: whoever drives the pipeline/debug side.
interface regfile_wport_sched_if #(
    parameter int XLEN  = rf_sched_pkg::XLEN,
    parameter int IDX_W = rf_sched_pkg::RF_IDX_W
) ();
    logic             wb_en;
    logic [IDX_W-1:0] wb_rd_index;
    logic [XLEN-1:0]  wb_data;
    logic             dbg_wr_valid;
    logic [IDX_W-1:0] dbg_wr_index;
    logic [XLEN-1:0]  dbg_wr_data;
    logic             dbg_wr_ready;
    logic             rf_wb_en;
    logic [IDX_W-1:0] rf_rd_index;
    logic [XLEN-1:0]  rf_wb_data;
    logic             stall_req;
    logic             init_done;

    modport slave (
        input  wb_en, wb_rd_index, wb_data,
        input  dbg_wr_valid, dbg_wr_index, dbg_wr_data,
        output dbg_wr_ready, rf_wb_en, rf_rd_index, rf_wb_data,
        output stall_req, init_done
    );

    modport master (
        output wb_en, wb_rd_index, wb_data,
        output dbg_wr_valid, dbg_wr_index, dbg_wr_data,
        input  dbg_wr_ready, rf_wb_en, rf_rd_index, rf_wb_data,
        input  stall_req, init_done
    );
endinterface

// File: rtl/regfile_wport_sched_starve_counter.sv
// Saturating count of cycles a pending debug write has been refused.
// hit flags the increment that brings the count up to the limit.
module starve_counter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit,
    output logic hit
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C    = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_M1_C = CNT_W'(STARVE_LIMIT - 1);

    logic [CNT_W-1:0] cnt_r;

    // Count refused cycles, clear on grant, hold at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && (cnt_r != LIMIT_C)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign at_limit = (cnt_r == LIMIT_C);
    assign hit      = inc && (cnt_r >= LIMIT_M1_C);
endmodule

// File: rtl/regfile_wport_sched.sv
// Write-port scheduler for the 32x32 register file: clears x1..x31 after
// reset, then arbitrates between pipeline writeback (priority) and a debug
// writer, stalling the pipeline when the debug writer is starved.
module regfile_wport_sched
    import rf_sched_pkg::sched_state_e;
    import rf_sched_pkg::ST_INIT;
    import rf_sched_pkg::ST_RUN;
    import rf_sched_pkg::ST_STALL;
    import rf_sched_pkg::RF_IDX_W;
#(
    parameter int              NUM_REGS     = rf_sched_pkg::NUM_REGS,
    parameter int              XLEN         = rf_sched_pkg::XLEN,
    parameter int              STARVE_LIMIT = 4,
    parameter logic [XLEN-1:0] INIT_VALUE   = {XLEN{1'b0}}
) (
    input logic                  clk,
    input logic                  rst,
    regfile_wport_sched_if.slave bus
);
    localparam logic [RF_IDX_W-1:0] LAST_IDX_C  = RF_IDX_W'(NUM_REGS - 1);
    localparam logic [RF_IDX_W-1:0] FIRST_IDX_C = 5'd1;

    sched_state_e        state_r, state_s;
    logic [RF_IDX_W-1:0] init_cnt_r, init_cnt_s;
    logic                pipe_wr_s;
    logic                inc_s, clr_s, at_limit_s, hit_s;
    logic                wen_s, ready_s;
    logic [RF_IDX_W-1:0] widx_s;
    logic [XLEN-1:0]     wdata_s;

    starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (inc_s),
        .clr      (clr_s),
        .at_limit (at_limit_s),
        .hit      (hit_s)
    );

    assign pipe_wr_s = bus.wb_en && (bus.wb_rd_index != 5'd0);

    // State and init-index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_INIT;
            init_cnt_r <= FIRST_IDX_C;
        end else begin
            state_r    <= state_s;
            init_cnt_r <= init_cnt_s;
        end
    end

    // Next-state and write-port selection.
    always_comb begin
        state_s    = state_r;
        init_cnt_s = init_cnt_r;
        wen_s      = 1'b0;
        widx_s     = 5'd0;
        wdata_s    = {XLEN{1'b0}};
        ready_s    = 1'b0;
        inc_s      = 1'b0;
        clr_s      = 1'b0;
        case (state_r)
            ST_INIT: begin
                wen_s      = 1'b1;
                widx_s     = init_cnt_r;
                wdata_s    = INIT_VALUE;
                init_cnt_s = init_cnt_r + 5'd1;
                if (init_cnt_r == LAST_IDX_C) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_INIT;
                end
            end
            ST_RUN: begin
                if (pipe_wr_s) begin
                    wen_s   = 1'b1;
                    widx_s  = bus.wb_rd_index;
                    wdata_s = bus.wb_data;
                    inc_s   = bus.dbg_wr_valid;
                    if (hit_s) begin
                        state_s = ST_STALL;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    ready_s = 1'b1;
                    if (bus.dbg_wr_valid) begin
                        wen_s   = (bus.dbg_wr_index != 5'd0);
                        widx_s  = bus.dbg_wr_index;
                        wdata_s = bus.dbg_wr_data;
                        clr_s   = 1'b1;
                    end else begin
                        wen_s = 1'b0;
                    end
                end
            end
            ST_STALL: begin
                if (pipe_wr_s) begin
                    // Pipeline ignored the stall; it still owns the port.
                    wen_s   = 1'b1;
                    widx_s  = bus.wb_rd_index;
                    wdata_s = bus.wb_data;
                    if (bus.dbg_wr_valid) begin
                        inc_s   = !at_limit_s;
                        state_s = ST_STALL;
                    end else begin
                        clr_s   = 1'b1;
                        state_s = ST_RUN;
                    end
                end else begin
                    ready_s = 1'b1;
                    clr_s   = 1'b1;
                    state_s = ST_RUN;
                    if (bus.dbg_wr_valid) begin
                        wen_s   = (bus.dbg_wr_index != 5'd0);
                        widx_s  = bus.dbg_wr_index;
                        wdata_s = bus.dbg_wr_data;
                    end else begin
                        wen_s = 1'b0;
                    end
                end
            end
            default: begin
                state_s    = ST_INIT;
                init_cnt_s = FIRST_IDX_C;
            end
        endcase
    end

    // Drive outputs, forcing reset values while rst is held.
    always_comb begin
        bus.rf_wb_en     = 1'b0;
        bus.rf_rd_index  = 5'd0;
        bus.rf_wb_data   = {XLEN{1'b0}};
        bus.dbg_wr_ready = 1'b0;
        bus.stall_req    = 1'b1;
        bus.init_done    = 1'b0;
        if (rst) begin
            bus.rf_wb_en     = 1'b0;
            bus.dbg_wr_ready = 1'b0;
        end else begin
            bus.rf_wb_en     = wen_s;
            bus.rf_rd_index  = widx_s;
            bus.rf_wb_data   = wdata_s;
            bus.dbg_wr_ready = ready_s;
            bus.stall_req    = (state_r != ST_RUN);
            bus.init_done    = (state_r != ST_INIT);
        end
    end
endmodule

// File: tb/tb_regfile_wport_sched.sv
// Self-checking bench for regfile_wport_sched.
module tb_regfile_wport_sched;
    logic clk;
    logic rst;

    regfile_wport_sched_if bus ();

    regfile_wport_sched #(.STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic [4:0]  idx;
        logic [31:0] data;
        logic        ready;
        logic        stall;
        logic        done;
        logic        chk_bus;
    } exp_t;

    typedef struct {
        string       name;
        logic        we;
        logic [4:0]  wi;
        logic [31:0] wd;
        logic        dv;
        logic [4:0]  di;
        logic [31:0] dd;
        exp_t        e;
    } vec_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[7];

    function automatic exp_t mk(input logic en, input logic [4:0] idx, input logic [31:0] data,
                                input logic ready, input logic stall, input logic done,
                                input logic chk_bus);
        exp_t e;
        e.en = en; e.idx = idx; e.data = data; e.ready = ready;
        e.stall = stall; e.done = done; e.chk_bus = chk_bus;
        return e;
    endfunction

    task automatic cmp(input string name, input string fld, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %h want %h", name, fld, act, exp);
        end
    endtask

    task automatic check_out(input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty got %h want entry", name, 32'd0);
        end else begin
            e = exp_q.pop_front();
            cmp(name, "rf_wb_en", {31'd0, bus.rf_wb_en}, {31'd0, e.en});
            cmp(name, "ready", {31'd0, bus.dbg_wr_ready}, {31'd0, e.ready});
            cmp(name, "stall", {31'd0, bus.stall_req}, {31'd0, e.stall});
            cmp(name, "done", {31'd0, bus.init_done}, {31'd0, e.done});
            if (e.chk_bus) begin
                cmp(name, "idx", {27'd0, bus.rf_rd_index}, {27'd0, e.idx});
                cmp(name, "data", bus.rf_wb_data, e.data);
            end
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wi, input logic [31:0] wd,
                         input logic dv, input logic [4:0] di, input logic [31:0] dd);
        bus.wb_en = we; bus.wb_rd_index = wi; bus.wb_data = wd;
        bus.dbg_wr_valid = dv; bus.dbg_wr_index = di; bus.dbg_wr_data = dd;
    endtask

    // Drive one cycle's inputs, queue the expectation, compare after settling.
    task automatic apply(input string name, input logic we, input logic [4:0] wi, input logic [31:0] wd,
                         input logic dv, input logic [4:0] di, input logic [31:0] dd, input exp_t e);
        drive(we, wi, wd, dv, di, dd);
        exp_q.push_back(e);
        #2;
        check_out(name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"wb_vs_dbg", 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd6, 32'h1,
                    mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b1)};
        vecs[1] = '{"dbg_grant6", 1'b0, 5'd5, 32'h0, 1'b1, 5'd6, 32'h1,
                    mk(1'b1, 5'd6, 32'h1, 1'b1, 1'b0, 1'b1, 1'b1)};
        vecs[2] = '{"wb_idx0_dbg9", 1'b1, 5'd0, 32'h55, 1'b1, 5'd9, 32'hA5A5A5A5,
                    mk(1'b1, 5'd9, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b1, 1'b1)};
        vecs[3] = '{"dbg_idx0", 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF,
                    mk(1'b0, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b1)};
        vecs[4] = '{"idle", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    mk(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0)};
        vecs[5] = '{"wb_x31", 1'b1, 5'd31, 32'h12, 1'b0, 5'd0, 32'h0,
                    mk(1'b1, 5'd31, 32'h12, 1'b0, 1'b0, 1'b1, 1'b1)};
        vecs[6] = '{"wb_en_low", 1'b0, 5'd4, 32'h77, 1'b0, 5'd0, 32'h0,
                    mk(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0)};

        // Reset state.
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        exp_q.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1));
        #3;
        check_out("reset");

        // Clear sequence x1..x31, pipeline writes ignored.
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            if (i > 1) @(negedge clk);
            apply($sformatf("init%0d", i), 1'b1, 5'd2, 32'hBAD, 1'b0, 5'd0, 32'h0,
                  mk(1'b1, 5'(i), 32'h0, 1'b0, 1'b1, 1'b0, 1'b1));
        end

        // Single-cycle RUN vectors.
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            apply(vecs[v].name, vecs[v].we, vecs[v].wi, vecs[v].wd, vecs[v].dv, vecs[v].di,
                  vecs[v].dd, vecs[v].e);
        end

        // Starvation: four refused cycles, then stall.
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            apply($sformatf("starve%0d", c), 1'b1, 5'd3, 32'hC0DE, 1'b1, 5'd7, 32'h12345678,
                  mk(1'b1, 5'd3, 32'hC0DE, 1'b0, 1'b0, 1'b1, 1'b1));
        end
        @(negedge clk);
        apply("stall_violation", 1'b1, 5'd3, 32'hC0DE, 1'b1, 5'd7, 32'h12345678,
              mk(1'b1, 5'd3, 32'hC0DE, 1'b0, 1'b1, 1'b1, 1'b1));
        @(negedge clk);
        apply("stall_grant", 1'b0, 5'd3, 32'hC0DE, 1'b1, 5'd7, 32'h12345678,
              mk(1'b1, 5'd7, 32'h12345678, 1'b1, 1'b1, 1'b1, 1'b1));
        @(negedge clk);
        apply("back_to_run", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
              mk(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0));

        // Get into STALL again, then reset asynchronously.
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            apply($sformatf("restarve%0d", c), 1'b1, 5'd3, 32'hC0DE, 1'b1, 5'd7, 32'h12345678,
                  mk(1'b1, 5'd3, 32'hC0DE, 1'b0, 1'b0, 1'b1, 1'b1));
        end
        @(negedge clk);
        apply("restall", 1'b1, 5'd3, 32'hC0DE, 1'b1, 5'd7, 32'h12345678,
              mk(1'b1, 5'd3, 32'hC0DE, 1'b0, 1'b1, 1'b1, 1'b1));
        #1;
        rst = 1'b1;
        exp_q.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1));
        #1;
        check_out("async_reset");

        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            if (i > 1) @(negedge clk);
            apply($sformatf("reinit%0d", i), 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12345678,
                  mk(1'b1, 5'(i), 32'h0, 1'b0, 1'b1, 1'b0, 1'b1));
        end
        @(negedge clk);
        apply("pending_dbg", 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12345678,
              mk(1'b1, 5'd7, 32'h12345678, 1'b1, 1'b0, 1'b1, 1'b1));
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
